// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter (TX FIFO + 8N1 serial engine)
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        hit,
  output logic        tx,
  output logic        irq
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_div;
  logic          r_overflow;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_shift;
  logic [15:0]   r_cnt;
  logic [15:0]   r_frame_div;
  logic [2:0]    r_bit_idx;
`ifdef UART_TX_PARITY_EN
  logic          r_parity;
`endif
  logic          r_hit;
  logic [31:0]   r_rdata;

  logic [29:0] w_word;
  logic        w_sel_data;
  logic        w_sel_status;
  logic        w_sel_div;
  logic        w_in_range;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push_ok;
  logic        w_push_drop;
  logic        w_bit_end;
  logic [7:0]  w_head;
  logic [31:0] w_count_ext;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_tx;
  logic        w_unused;

  assign w_word       = address[31:2];
  assign w_sel_data   = (w_word == BASE_ADDR[31:2]);
  assign w_sel_status = (w_word == BASE_ADDR[31:2] + 30'd1);
  assign w_sel_div    = (w_word == BASE_ADDR[31:2] + 30'd2);
  assign w_in_range   = w_sel_data | w_sel_status | w_sel_div;
  assign w_unused     = &{1'b0, address[1:0], data_in[31:16]};

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_busy      = (r_state != S_IDLE);
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_push_req  = wr && w_sel_data;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push_ok   = w_push_req && (!w_full || w_pop);
  assign w_push_drop = w_push_req && !w_push_ok;
  assign w_bit_end   = (r_cnt == 16'd1);
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div      <= DEFAULT_DIV;
      r_overflow <= 1'b0;
    end else begin
      if (wr && w_sel_div)
        r_div <= (data_in[15:0] == 16'd0) ? 16'd1 : data_in[15:0];
      if (w_push_drop)
        r_overflow <= 1'b1;
      else if (wr && w_sel_status && data_in[3])
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_next = S_START;
      S_START:  if (w_bit_end) w_state_next = S_DATA;
      S_DATA:   if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_AFTER_DATA;
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
      S_STOP:   if (w_bit_end) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Bit period is frozen per frame so BAUDDIV writes only affect the next START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_frame_div <= '0;
      r_bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else if (w_pop) begin
      r_shift     <= w_head;
      r_cnt       <= r_div;
      r_frame_div <= r_div;
      r_bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= ^w_head;
`endif
    end else if (w_busy) begin
      if (w_bit_end) begin
        r_cnt <= r_frame_div;
        if (r_state == S_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      S_START:  w_tx = 1'b0;
      S_DATA:   w_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx = r_parity;
`endif
      default:  w_tx = 1'b1;
    endcase
  end

  assign tx  = w_tx;
  assign irq = !w_busy && w_empty;

  assign w_count_ext = 32'(r_count);
  assign w_status    = {24'd0, w_count_ext[3:0], r_overflow, w_busy, w_empty, w_full};

  always_comb begin
    w_rdata = 32'd0;
    if (w_sel_status)   w_rdata = w_status;
    else if (w_sel_div) w_rdata = {16'd0, r_div};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_hit   <= w_in_range && !wr;
      r_rdata <= (w_in_range && !wr) ? w_rdata : 32'd0;
    end
  end

  assign hit      = r_hit;
  assign data_out = r_rdata;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS  = 11;
  localparam logic [10:0] EXP_A5 = 11'b10101001010;
  localparam logic [10:0] EXP_07 = 11'b11000001110;
`else
  localparam int          NBITS  = 10;
  localparam logic [10:0] EXP_A5 = 11'b01101001010;
  localparam logic [10:0] EXP_07 = 11'b01000001110;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = 32'd0;
  logic        wr = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        hit;
  logic        tx;
  logic        irq;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rd;

  mmio_uart_tx dut (
    .clk(clk), .reset(rst_n), .address(address), .wr(wr),
    .data_in(data_in), .data_out(data_out), .hit(hit), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address = a; data_in = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; address = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address = a; wr = 1'b0;
    @(posedge clk); #1;
    d = data_out;
    check("read_hit", hit, 1);
    address = 32'd0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [10:0] exp_bits, input int div);
    bus_write(BASE, {24'd0, b});
    check("irq_after_push", irq, 0);
    check("write_no_hit", hit, 0);
    for (int i = 0; i < NBITS; i++)
      for (int j = 0; j < div; j++) begin
        @(posedge clk); #1;
        check("tx_bit", tx, exp_bits[i]);
      end
    @(posedge clk); #1;
    check("irq_frame_done", irq, 1);
    check("tx_idle", tx, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_irq", irq, 1);
    check("reset_hit", hit, 0);
    check("reset_dout", data_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_hit", hit, 0);

    bus_read(BASE + 32'd8, rd);
    check("div_default", rd, 32'd434);
    bus_read(BASE + 32'd4, rd);
    check("status_reset", rd, 32'h2);
    bus_read(BASE, rd);
    check("txdata_read", rd, 32'h0);
    @(posedge clk); #1;
    check("hit_clears", hit, 0);
    check("dout_clears", data_out, 0);

    bus_write(BASE + 32'd8, 32'd4);
    send_frame(8'hA5, EXP_A5, 4);

    bus_write(BASE + 32'd8, 32'd2);
    for (int i = 0; i < 5; i++) bus_write(BASE, 32'h30 + i);
    bus_read(BASE + 32'd4, rd);
    check("status_five", rd, 32'h45);
    bus_write(BASE, 32'h55);
    bus_read(BASE + 32'd4, rd);
    check("status_overflow", rd, 32'h4D);
    bus_write(BASE + 32'd4, 32'h8);
    bus_read(BASE + 32'd4, rd);
    check("status_ovf_clear", rd, 32'h45);
    begin
      int k;
      k = 0;
      while (!irq && k < 400) begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("drain_irq", irq, 1);
    bus_read(BASE + 32'd4, rd);
    check("status_drained", rd, 32'h2);

    bus_write(BASE + 32'd8, 32'd0);
    bus_read(BASE + 32'd8, rd);
    check("div_zero_as_one", rd, 32'd1);
    send_frame(8'h07, EXP_07, 1);

    bus_write(BASE + 32'd8, 32'd4);
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    repeat (8) @(posedge clk);
    #1;
    check("pre_reset_busy", irq, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_irq", irq, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_tx", tx, 1);
    bus_read(BASE + 32'd4, rd);
    check("status_post_reset", rd, 32'h2);
    bus_read(BASE + 32'd8, rd);
    check("div_post_reset", rd, 32'd434);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
